// File: rtl/jtcps1_pal_pkg.sv
// Shared definitions for the CPS1 palette DMA sequencer.
// It holds the FSM state encoding, the page geometry and the palette page indices.
package jtcps1_pal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SCAN,
    ST_ADDR,
    ST_DROP,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int PAGE_WORDS = 512;

  localparam logic [2:0] PG_OBJ   = 3'd0;
  localparam logic [2:0] PG_SCR1  = 3'd1;
  localparam logic [2:0] PG_SCR2  = 3'd2;
  localparam logic [2:0] PG_SCR3  = 3'd3;
  localparam logic [2:0] PG_STAR0 = 3'd4;
  localparam logic [2:0] PG_STAR1 = 3'd5;

endpackage

// File: rtl/jtcps1_pal_dma_if.sv
// Bus bundle between the palette DMA and its two neighbours:
// the VRAM read port and the colour mixer palette write port.
interface jtcps1_pal_dma_if #(
  parameter int PAL_AW = 12
);
  // VRAM read: vram_cs is a request that stays high for the whole transfer.
  // vram_ok qualifies vram_data for the address currently on vram_addr.
  // There is no ready: vram_ok alone accepts a word.
  // Palette write: pal_we is a one-cycle strobe with no backpressure.
  logic [16:0]       vram_addr;
  logic              vram_cs;
  logic [15:0]       vram_data;
  logic              vram_ok;
  logic              pal_we;
  logic [PAL_AW-1:0] pal_waddr;
  logic [15:0]       pal_wdata;

  modport master (
    output vram_addr, vram_cs, pal_we, pal_waddr, pal_wdata,
    input  vram_data, vram_ok
  );

  modport slave (
    input  vram_addr, vram_cs, pal_we, pal_waddr, pal_wdata,
    output vram_data, vram_ok
  );
endinterface

// File: rtl/jtcps1_pal_pgsel.sv
// Lowest enabled palette page at or above the current page index.
// The search is purely combinational.
module jtcps1_pal_pgsel
  import jtcps1_pal_pkg::*;
#(
  parameter int PAGES = 6,
  parameter int PG_W  = 3
) (
  input  logic [PAGES-1:0] mask_i,
  input  logic [PG_W-1:0]  idx_i,
  output logic [PG_W-1:0]  page_o,
  output logic             found_o
);

  // Scan from the top down so the last hit is the lowest qualifying page.
  always_comb begin
    page_o  = '0;
    found_o = 1'b0;
    for (int p = PAGES - 1; p >= 0; p--) begin
      if (mask_i[p] && (PG_W'(p) >= idx_i)) begin
        page_o  = PG_W'(p);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcps1_pal_dma.sv
// Palette DMA: copies the enabled VRAM palette pages into the colour mixer palette RAM.
// Optional JTCPS1_PAL_VBSYNC_EN holds each transfer start until vertical blank.
module jtcps1_pal_dma
  import jtcps1_pal_pkg::*;
#(
  parameter int PAGES   = 6,
  parameter int PAGE_AW = 9,
  parameter int PAL_AW  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                VB,
  input  logic                pal_copy,
  input  logic [15:0]         pal_base,
  input  logic [PAGES-1:0]    pal_page_en,
  jtcps1_pal_dma_if.master    bus,
  output logic                busy,
  output logic                done,
  output state_e              dbg_state
);

  localparam int PG_W  = $clog2(PAGES + 1);
  localparam int SRC_W = PG_W + PAGE_AW;

  state_e             state_q;
  logic [8:0]         base_q;
  logic [PAGES-1:0]   en_q;
  logic               pending_q;
  logic [PG_W-1:0]    page_q;
  logic [PAGE_AW-1:0] word_q;
  logic [SRC_W-1:0]   src_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [16:0]        vram_addr_q;
  logic               vram_cs_q;
  logic               pal_we_q;
  logic [PAL_AW-1:0]  pal_waddr_q;
  logic [15:0]        pal_wdata_q;

  logic [PG_W-1:0]    sel_page;
  logic               sel_found;

  jtcps1_pal_pgsel #(
    .PAGES (PAGES),
    .PG_W  (PG_W)
  ) u_pgsel (
    .mask_i  (en_q),
    .idx_i   (page_q),
    .page_o  (sel_page),
    .found_o (sel_found)
  );

`ifdef JTCPS1_PAL_VBSYNC_EN
  logic unused_bits;
  assign unused_bits = &{1'b0, pal_base[15:10], pal_base[0]};
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, pal_base[15:10], pal_base[0], VB};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      en_q        <= '0;
      pending_q   <= 1'b0;
      page_q      <= '0;
      word_q      <= '0;
      src_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vram_addr_q <= '0;
      vram_cs_q   <= 1'b0;
      pal_we_q    <= 1'b0;
      pal_waddr_q <= '0;
      pal_wdata_q <= '0;
    end else begin
      pal_we_q <= 1'b0;
      done_q   <= 1'b0;
      // Requests during a transfer merge into one pending restart.
      if (pal_copy && state_q != ST_IDLE && state_q != ST_DONE) pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pal_copy) begin
            base_q    <= pal_base[9:1];
            en_q      <= pal_page_en;
            page_q    <= '0;
            src_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
`ifdef JTCPS1_PAL_VBSYNC_EN
          if (VB) state_q <= ST_SCAN;
`else
          state_q <= ST_SCAN;
`endif
        end
        ST_SCAN: begin
          if (sel_found) begin
            page_q    <= sel_page;
            word_q    <= '0;
            vram_cs_q <= 1'b1;
            state_q   <= ST_ADDR;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_ADDR: begin
          vram_addr_q <= {base_q, 8'd0} + 17'(src_cnt_q);
          state_q     <= ST_DROP;
        end
        // vram_ok may still refer to the previous address here.
        ST_DROP: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bus.vram_ok) begin
            pal_we_q    <= 1'b1;
            pal_waddr_q <= PAL_AW'({page_q, word_q});
            pal_wdata_q <= bus.vram_data;
            state_q     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          word_q    <= word_q + 1'b1;
          src_cnt_q <= src_cnt_q + 1'b1;
          if (&word_q) begin
            page_q  <= page_q + 1'b1;
            state_q <= ST_SCAN;
          end else begin
            state_q <= ST_ADDR;
          end
        end
        ST_DONE: begin
          vram_cs_q <= 1'b0;
          done_q    <= 1'b1;
          if (pending_q || pal_copy) begin
            base_q    <= pal_base[9:1];
            en_q      <= pal_page_en;
            page_q    <= '0;
            src_cnt_q <= '0;
            pending_q <= 1'b0;
            state_q   <= ST_ARM;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_cs   = vram_cs_q;
  assign bus.pal_we    = pal_we_q;
  assign bus.pal_waddr = pal_waddr_q;
  assign bus.pal_wdata = pal_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Self-checking bench for jtcps1_pal_dma.
// A VRAM responder with random latency feeds a scoreboard of expected palette writes.
module tb_jtcps1_pal_dma;
  import jtcps1_pal_pkg::*;

  localparam int W = 45;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        VB = 1'b1;
  logic        pal_copy = 1'b0;
  logic [15:0] pal_base = '0;
  logic [5:0]  pal_page_en = '0;
  logic        busy;
  logic        done;
  state_e      dbg_state;

  jtcps1_pal_dma_if #(.PAL_AW(12)) bus();

  jtcps1_pal_dma dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .VB          (VB),
    .pal_copy    (pal_copy),
    .pal_base    (pal_base),
    .pal_page_en (pal_page_en),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  int cs_cycles = 0;
  int mcycle = 0;
  int last_we = 0;
  bit ok_always = 1'b0;
  bit chk_spacing = 1'b0;
  logic [16:0] last_addr;
  int lat;

  function automatic logic [15:0] vram_word(input logic [16:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {15'd0, a[16]};
  endfunction

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- VRAM responder ----------------
  always @(negedge clk) begin
    if (ok_always) begin
      bus.vram_ok   = 1'b1;
      bus.vram_data = vram_word(bus.vram_addr);
    end else if (bus.vram_addr !== last_addr) begin
      last_addr     = bus.vram_addr;
      lat           = $urandom_range(0, 3);
      bus.vram_ok   = 1'b0;
      bus.vram_data = 16'hDEAD;
    end else if (lat > 0) begin
      lat--;
    end else begin
      bus.vram_ok   = 1'b1;
      bus.vram_data = vram_word(last_addr);
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      mcycle++;
      if (bus.vram_cs) cs_cycles++;
      if (done) done_cnt++;
      if (bus.pal_we) begin
        we_cnt++;
        check("we_expected", 48'(exp_q.size() != 0), 48'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("vram_addr", 48'(bus.vram_addr), 48'(mon_e[44:28]));
          check("pal_waddr", 48'(bus.pal_waddr), 48'(mon_e[27:16]));
          check("pal_wdata", 48'(bus.pal_wdata), 48'(mon_e[15:0]));
        end
        if (chk_spacing && bus.pal_waddr[8:0] != 9'd0)
          check("word_cycles", 48'(mcycle - last_we), 48'd4);
        last_we = mcycle;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_copy(input logic [15:0] base, input logic [5:0] en);
    int k = 0;
    logic [16:0] a;
    for (int p = 0; p < 6; p++) begin
      if (en[p]) begin
        for (int w = 0; w < 512; w++) begin
          a = {base[9:1], 8'd0} + 17'(k * 512 + w);
          exp_q.push_back({a, 12'(p * 512 + w), vram_word(a)});
        end
        k++;
      end
    end
  endtask

  task automatic request(input logic [15:0] base, input logic [5:0] en);
    @(negedge clk);
    pal_base    = base;
    pal_page_en = en;
    pal_copy    = 1'b1;
    @(negedge clk);
    pal_copy    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(tag, 48'(done_cnt), 48'(target));
    check({tag, "_busy"}, 48'(busy), 48'd0);
    check({tag, "_qempty"}, 48'(exp_q.size()), 48'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int w0;
    int c0;
    int n;
    bus.vram_ok   = 1'b0;
    bus.vram_data = '0;
    last_addr     = '0;
    lat           = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_cs", 48'(bus.vram_cs), 48'd0);
    check("rst_we", 48'(bus.pal_we), 48'd0);
    check("rst_vaddr", 48'(bus.vram_addr), 48'd0);
    check("rst_waddr", 48'(bus.pal_waddr), 48'd0);
    check("rst_wdata", 48'(bus.pal_wdata), 48'd0);
    check("rst_state", 48'(dbg_state), 48'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single OBJ page from VRAM 0x2000.
    d0 = done_cnt; w0 = we_cnt;
    push_copy(16'h0040, 6'b000001);
    request(16'h0040, 6'b000001);
    wait_done("A_done", d0 + 1, 6000);
    check("A_writes", 48'(we_cnt - w0), 48'd512);

    // Pages 0 and 2, packed source; VB drops mid-transfer.
    d0 = done_cnt; w0 = we_cnt;
    push_copy(16'h0000, 6'b000101);
    request(16'h0000, 6'b000101);
    repeat (3000) @(negedge clk);
    VB = 1'b0;
    wait_done("B_done", d0 + 1, 9000);
    check("B_writes", 48'(we_cnt - w0), 48'd1024);
    VB = 1'b1;

    // Empty mask: no VRAM access, done three cycles after the request.
    d0 = done_cnt; c0 = cs_cycles;
    request(16'h0040, 6'b000000);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("C_latency", 48'(n), 48'd3);
    check("C_busy", 48'(busy), 48'd0);
    wait_done("C_done", d0 + 1, 20);
    check("C_cs_cycles", 48'(cs_cycles - c0), 48'd0);

    // Mid-transfer requests merge into exactly one further copy with the new base.
    d0 = done_cnt; w0 = we_cnt;
    push_copy(16'h0040, 6'b000001);
    request(16'h0040, 6'b000001);
    repeat (1000) @(negedge clk);
    push_copy(16'h0100, 6'b000010);
    request(16'h0100, 6'b000010);
    repeat (50) @(negedge clk);
    request(16'h0100, 6'b000010);
    wait_done("D_done", d0 + 2, 14000);
    check("D_writes", 48'(we_cnt - w0), 48'd1024);

    // vram_ok stuck high: four cycles per word, source address wraps at 2^17.
    d0 = done_cnt; w0 = we_cnt;
    ok_always   = 1'b1;
    chk_spacing = 1'b1;
    push_copy(16'h03FE, 6'b100000);
    request(16'h03FE, 6'b100000);
    wait_done("E_done", d0 + 1, 4000);
    check("E_writes", 48'(we_cnt - w0), 48'd512);
    chk_spacing = 1'b0;
    ok_always   = 1'b0;

    // Reset during word 100 kills the transfer at once.
    w0 = we_cnt;
    push_copy(16'h0040, 6'b000001);
    request(16'h0040, 6'b000001);
    n = 0;
    while ((we_cnt - w0) < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("F_reach_word", 48'((we_cnt - w0) >= 100), 48'd1);
    #2 rst_n = 1'b0;
    #1;
    check("F_cs", 48'(bus.vram_cs), 48'd0);
    check("F_we", 48'(bus.pal_we), 48'd0);
    check("F_busy", 48'(busy), 48'd0);
    check("F_state", 48'(dbg_state), 48'(ST_IDLE));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef JTCPS1_PAL_VBSYNC_EN
    // Outside vblank the request waits in ARM with VRAM untouched.
    d0 = done_cnt;
    VB = 1'b0;
    push_copy(16'h0040, 6'b000001);
    request(16'h0040, 6'b000001);
    repeat (20) @(negedge clk);
    check("V_cs_hold", 48'(bus.vram_cs), 48'd0);
    check("V_busy", 48'(busy), 48'd1);
    check("V_state", 48'(dbg_state), 48'(ST_ARM));
    VB = 1'b1;
    wait_done("V_done", d0 + 1, 6000);
`endif

    // Normal operation after reset.
    d0 = done_cnt; w0 = we_cnt;
    push_copy(16'h0200, 6'b001000);
    request(16'h0200, 6'b001000);
    wait_done("G_done", d0 + 1, 6000);
    check("G_writes", 48'(we_cnt - w0), 48'd512);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcps1_pal_dma.md
Name: jtcps1_pal_dma

Overview:
- Palette DMA sequencer feeding the colour mixer's palette RAM.
- On a CPU palette-copy request it copies only the enabled palette pages from VRAM into the mixer palette write port.
- Up to 6 pages of 512 words each: OBJ, SCR1, SCR2, SCR3, STAR0, STAR1.
- Owns the VRAM read handshake for the whole transfer; sits between the CPS-A register block and jtcps1_colmix.

Parameters:
PAGES, 6, number of palette pages
PAGE_AW, 9, log2 words per page (512)
PAL_AW, 12, palette RAM address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
VB  in  1  vertical blank, active high
pal_copy  in  1  one-cycle copy request from CPU register write
pal_base  in  16  palette base register; source word address = {pal_base[9:1],8'd0}
pal_page_en  in  6  page enable mask, bit p = page p
vram_addr  out  17  VRAM word address [17:1]
vram_cs  out  1  VRAM read request, held for the whole transfer
vram_data  in  16  VRAM read data
vram_ok  in  1  read data valid for the current vram_addr
pal_we  out  1  palette write strobe, one cycle per word
pal_waddr  out  12  palette write address
pal_wdata  out  16  palette write data
busy  out  1  high from request latch to completion
done  out  1  one-cycle pulse at end of a transfer

Behaviour:
- Reset (asynchronous, any state, including mid-transfer): state IDLE; vram_cs=0; pal_we=0; done=0; busy=0; vram_addr=0; pal_waddr=0; pal_wdata=0; pending=0. A partially written palette is left as-is.
- Request latch: on pal_copy, capture pal_base[9:1] and pal_page_en into shadow registers. Later register changes do not affect a transfer in flight.
- States:
  - IDLE: on pal_copy -> ARM, busy=1.
  - ARM: go to SCAN (gating per Optional Feature).
  - SCAN: find the lowest enabled page p >= current page index. If none -> DONE. Otherwise dst = p*512, vram_cs=1 -> ADDR.
  - ADDR: vram_addr = base + src_cnt -> DROP.
  - DROP: one cycle; vram_ok is ignored so a stale ok is not sampled -> WAIT.
  - WAIT: stay while vram_ok=0. On vram_ok: pal_we=1, pal_waddr = dst + word, pal_wdata = vram_data -> NEXT.
  - NEXT: word+1 and src_cnt+1. If word wraps from 511 to 0: page index +1 -> SCAN. Otherwise -> ADDR.
  - DONE: vram_cs=0, done=1 for one cycle. If pending, re-latch and -> ARM; else busy=0 -> IDLE.
- Source addressing is packed: src_cnt advances only for enabled pages. Enabled page k of n reads base + k*512.
- Destination addressing is fixed per page: disabled pages are left untouched in the palette.
- vram_addr is a 17-bit sum that wraps modulo 2^17.
- Minimum cost is 4 cycles per word. A full 6-page copy takes ≥ 12288 cycles plus one SCAN per page.
- pal_copy while busy sets pending (depth 1, further requests merge). Shadow registers are re-captured when the pending request starts.
- pal_copy in the same cycle as done: treated as pending and restarts immediately.
- pal_page_en=0: SCAN -> DONE with no VRAM access; done still pulses.
- VB falling mid-transfer does not abort the transfer.

Optional Feature:
- Macro JTCPS1_PAL_VBSYNC_EN.
- Defined: ARM waits until VB=1 before entering SCAN, so transfers start only inside vertical blank. A request made during vblank starts at once.
- Undefined: ARM moves to SCAN on the next cycle regardless of VB.

Decomposition:
- Package jtcps1_pal_pkg holds:
  - state encoding localparams (IDLE, ARM, SCAN, ADDR, DROP, WAIT, NEXT, DONE)
  - PAGE_WORDS=512
  - page index constants (OBJ=0 … STAR1=5)
- One sub-module, jtcps1_pal_pgsel: combinational lowest-set-bit finder over the page mask at or above the current index. Outputs the page number plus a found flag.

Test Plan:
- pal_base=16'h0040, pal_page_en=6'b000001, vram_ok one cycle after DROP -> 512 pal_we pulses; vram_addr 0x2000..0x21FF; pal_waddr 0..511; done once.
- pal_page_en=6'b000101, base 0 -> page 0 from VRAM 0x0000..0x01FF to pal 0..511; page 2 from VRAM 0x0200..0x03FF to pal 1024..1535; pal 512..1023 untouched.
- pal_page_en=0 -> zero vram_cs cycles; done 3 cycles after pal_copy; busy low afterwards.
- Second pal_copy mid-transfer with changed base -> first copy completes, then exactly one further copy uses the new base; two done pulses total.
- vram_ok held high continuously -> data is never captured in DROP; each word takes exactly 4 cycles.
- rst_n low during word 100 -> vram_cs and pal_we drop immediately. With JTCPS1_PAL_VBSYNC_EN, a request at VB=0 holds vram_cs low until VB rises.
